// File: rtl/change_dispenser.sv
// Return-path controller: inactivity timer, return-request latch and greedy
// one-coin-per-cycle change dispenser feeding the output regularizer.
module change_dispenser #(
    parameter int unsigned NUM_COINS   = 3,
    parameter int unsigned TOTAL_BITS  = 31,
    parameter int unsigned COIN_VAL0   = 100,
    parameter int unsigned COIN_VAL1   = 500,
    parameter int unsigned COIN_VAL2   = 1000,
    parameter int unsigned WAIT_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_trigger_return,
    input  logic                  i_activity,
    input  logic [TOTAL_BITS-1:0] current_total,
    output logic                  return_changes,
    output logic [NUM_COINS-1:0]  return_coin_1,
    output logic [TOTAL_BITS-1:0] change_remaining,
    output logic [TOTAL_BITS-1:0] wait_time,
    output logic                  dispense_done,
    output logic [TOTAL_BITS-1:0] residue
);

    localparam logic [TOTAL_BITS-1:0] WaitReload = TOTAL_BITS'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StDispense,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic                    return_changes_q, return_changes_d;
    logic [TOTAL_BITS-1:0]   change_remaining_q, change_remaining_d;
    logic [TOTAL_BITS-1:0]   wait_time_q, wait_time_d;
    logic                    dispense_done_q, dispense_done_d;
    logic [TOTAL_BITS-1:0]   residue_q, residue_d;

    logic [NUM_COINS-1:0]    coin_oh;
    logic [TOTAL_BITS-1:0]   coin_amt;
    logic                    req;

    // Denomination table; bits beyond the three defined coins are never selected.
    function automatic logic [TOTAL_BITS-1:0] coin_value(input int unsigned k);
        case (k)
            0:       coin_value = TOTAL_BITS'(COIN_VAL0);
            1:       coin_value = TOTAL_BITS'(COIN_VAL1);
            2:       coin_value = TOTAL_BITS'(COIN_VAL2);
            default: coin_value = '0;
        endcase
    endfunction

    // Greedy coin pick: denominations ascend with bit index, so the last fitting one wins.
    always_comb begin
        coin_oh  = '0;
        coin_amt = '0;
        if (state_q == StDispense) begin
            for (int unsigned k = 0; k < NUM_COINS; k++) begin
                if (coin_value(k) != '0 && change_remaining_q >= coin_value(k)) begin
                    coin_oh  = NUM_COINS'(1) << k;
                    coin_amt = coin_value(k);
                end
            end
        end
    end

    assign req = i_trigger_return | ((wait_time_q == '0) & (current_total != '0));

    // Next-state logic for the FSM, timer and burst bookkeeping.
    always_comb begin
        state_d            = state_q;
        return_changes_d   = return_changes_q;
        change_remaining_d = change_remaining_q;
        wait_time_d        = wait_time_q;
        dispense_done_d    = dispense_done_q;
        residue_d          = residue_q;
        unique case (state_q)
            StIdle: begin
                if (i_activity) begin
                    wait_time_d = WaitReload;
                end else if (current_total != '0 && wait_time_q != '0) begin
                    wait_time_d = wait_time_q - 1'b1;
                end
                // A return with nothing owed is dropped silently.
                if (req && current_total != '0) begin
                    state_d            = StDispense;
                    change_remaining_d = current_total;
                    return_changes_d   = 1'b1;
                    wait_time_d        = WaitReload;
                end
            end
            StDispense: begin
                if (coin_amt == '0) begin
                    state_d          = StDone;
                    return_changes_d = 1'b0;
                    residue_d        = change_remaining_q;
                    dispense_done_d  = 1'b1;
                end else begin
                    change_remaining_d = change_remaining_q - coin_amt;
                end
            end
            StDone: begin
                state_d            = StIdle;
                dispense_done_d    = 1'b0;
                change_remaining_d = '0;
                wait_time_d        = WaitReload;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= StIdle;
            return_changes_q   <= 1'b0;
            change_remaining_q <= '0;
            wait_time_q        <= WaitReload;
            dispense_done_q    <= 1'b0;
            residue_q          <= '0;
        end else begin
            state_q            <= state_d;
            return_changes_q   <= return_changes_d;
            change_remaining_q <= change_remaining_d;
            wait_time_q        <= wait_time_d;
            dispense_done_q    <= dispense_done_d;
            residue_q          <= residue_d;
        end
    end

    assign return_coin_1    = reset ? '0 : coin_oh;
    assign return_changes   = return_changes_q;
    assign change_remaining = change_remaining_q;
    assign wait_time        = wait_time_q;
    assign dispense_done    = dispense_done_q;
    assign residue          = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed literal cases plus randomized traffic
// checked every cycle against a plan-based behavioural model.
module tb_change_dispenser;

    localparam int unsigned TB = 31;
    localparam int unsigned W  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_trigger_return;
    logic          i_activity;
    logic [TB-1:0] current_total;
    logic          return_changes;
    logic [2:0]    return_coin_1;
    logic [TB-1:0] change_remaining;
    logic [TB-1:0] wait_time;
    logic          dispense_done;
    logic [TB-1:0] residue;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          cmp_en = 1'b0;

    change_dispenser #(
        .NUM_COINS  (3),
        .TOTAL_BITS (TB),
        .COIN_VAL0  (100),
        .COIN_VAL1  (500),
        .COIN_VAL2  (1000),
        .WAIT_CYCLES(W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_trigger_return(i_trigger_return),
        .i_activity      (i_activity),
        .current_total   (current_total),
        .return_changes  (return_changes),
        .return_coin_1   (return_coin_1),
        .change_remaining(change_remaining),
        .wait_time       (wait_time),
        .dispense_done   (dispense_done),
        .residue         (residue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0 = waiting, 1 = paying out, 2 = burst-finished cycle
    int unsigned m_phase = 0;
    int unsigned m_rem = 0, m_wait = W, m_res = 0, m_plan_res = 0;
    bit          m_rc = 0, m_done = 0;
    logic [2:0]  m_coins[$];

    function automatic int unsigned coin_amount(input logic [2:0] c);
        case (c)
            3'b100:  return 1000;
            3'b010:  return 500;
            3'b001:  return 100;
            default: return 0;
        endcase
    endfunction

    // The whole payout is decided up front by division, then replayed.
    task automatic m_plan(input int unsigned t);
        int unsigned r;
        r = t;
        m_coins.delete();
        repeat (r / 1000) m_coins.push_back(3'b100);
        r = r % 1000;
        repeat (r / 500) m_coins.push_back(3'b010);
        r = r % 500;
        repeat (r / 100) m_coins.push_back(3'b001);
        m_plan_res = r % 100;
    endtask

    task automatic m_reset();
        m_phase = 0; m_rem = 0; m_wait = W; m_res = 0; m_rc = 0; m_done = 0;
        m_coins.delete();
    endtask

    task automatic m_step();
        int unsigned tot;
        tot = 32'(current_total);
        case (m_phase)
            0: begin
                if ((i_trigger_return || m_wait == 0) && tot != 0) begin
                    m_phase = 1; m_rem = tot; m_rc = 1; m_wait = W;
                    m_plan(tot);
                end else if (i_activity) begin
                    m_wait = W;
                end else if (tot != 0 && m_wait > 0) begin
                    m_wait--;
                end
            end
            1: begin
                if (m_coins.size() > 0) m_rem -= coin_amount(m_coins.pop_front());
                else begin
                    m_phase = 2; m_rc = 0; m_done = 1; m_res = m_plan_res;
                end
            end
            default: begin
                m_phase = 0; m_done = 0; m_rem = 0; m_wait = W;
            end
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else m_step();
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m return_changes", 32'(return_changes), 32'(m_rc));
            chk("m return_coin_1", 32'(return_coin_1),
                (m_phase == 1 && m_coins.size() > 0) ? 32'(m_coins[0]) : 32'd0);
            chk("m change_remaining", 32'(change_remaining), m_rem);
            chk("m wait_time", 32'(wait_time), m_wait);
            chk("m dispense_done", 32'(dispense_done), 32'(m_done));
            chk("m residue", 32'(residue), m_res);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic burst(input string tag, input int unsigned total, input int n,
                         input logic [2:0] coins[3], input int unsigned crs[3],
                         input int unsigned res);
        current_total    = TB'(total);
        i_trigger_return = 1'b1;
        @(posedge clk); #1;
        i_trigger_return = 1'b0;
        current_total    = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, " coin"}, 32'(return_coin_1), 32'(coins[i]));
            chk({tag, " remaining"}, 32'(change_remaining), crs[i]);
            chk({tag, " busy"}, 32'(return_changes), 32'd1);
        end
        @(negedge clk);
        chk({tag, " last coin"}, 32'(return_coin_1), 32'd0);
        chk({tag, " last busy"}, 32'(return_changes), 32'd1);
        chk({tag, " last remaining"}, 32'(change_remaining), res);
        @(negedge clk);
        chk({tag, " done busy"}, 32'(return_changes), 32'd0);
        chk({tag, " done pulse"}, 32'(dispense_done), 32'd1);
        chk({tag, " residue"}, 32'(residue), res);
        @(negedge clk);
        chk({tag, " post pulse"}, 32'(dispense_done), 32'd0);
        chk({tag, " post remaining"}, 32'(change_remaining), 32'd0);
        chk({tag, " post wait"}, 32'(wait_time), W);
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (dispense_done) seen = 1'b1;
        end
        chk({tag, " burst ended"}, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        reset            = 1'b0;
        i_trigger_return = 1'b0;
        i_activity       = 1'b0;
        current_total    = '0;
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(return_changes), 32'd0);
        chk("reset coin", 32'(return_coin_1), 32'd0);
        chk("reset remaining", 32'(change_remaining), 32'd0);
        chk("reset wait", 32'(wait_time), W);
        chk("reset done", 32'(dispense_done), 32'd0);
        chk("reset residue", 32'(residue), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        burst("b1600", 1600, 3, '{3'b100, 3'b010, 3'b001}, '{1600, 600, 100}, 0);
        burst("b2100", 2100, 3, '{3'b100, 3'b100, 3'b001}, '{2100, 1100, 100}, 0);
        burst("b650", 650, 2, '{3'b010, 3'b001, 3'b000}, '{650, 150, 0}, 50);

        // Automatic return after inactivity, with a reload part way down.
        current_total = TB'(500);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wait_time == TB'(2)) found = 1'b1;
        end
        chk("auto reached 2", 32'(found), 32'd1);
        i_activity = 1'b1;
        @(posedge clk); #1;
        i_activity = 1'b0;
        @(negedge clk);
        chk("auto reload", 32'(wait_time), W);
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            chk("auto countdown", 32'(wait_time), 32'(k));
            chk("auto not yet", 32'(return_changes), 32'd0);
        end
        @(negedge clk);
        chk("auto started", 32'(return_changes), 32'd1);
        chk("auto coin", 32'(return_coin_1), 32'b010);
        current_total = '0;
        wait_idle("auto");

        // Return request with nothing owed.
        i_trigger_return = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("zero busy", 32'(return_changes), 32'd0);
            chk("zero done", 32'(dispense_done), 32'd0);
            chk("zero coin", 32'(return_coin_1), 32'd0);
        end
        i_trigger_return = 1'b0;

        // Reset in the middle of a burst.
        current_total    = TB'(3000);
        i_trigger_return = 1'b1;
        @(posedge clk); #1;
        i_trigger_return = 1'b0;
        current_total    = '0;
        @(negedge clk);
        chk("abort first coin", 32'(return_coin_1), 32'b100);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort coin", 32'(return_coin_1), 32'd0);
        chk("abort busy", 32'(return_changes), 32'd0);
        chk("abort remaining", 32'(change_remaining), 32'd0);
        chk("abort wait", 32'(wait_time), W);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort no pulse", 32'(dispense_done), 32'd0);
        end

        // Randomized traffic; the model check runs every cycle.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 149) == 0) reset = 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       current_total = '0;
                    1:       current_total = TB'(100 * $urandom_range(1, 40));
                    2:       current_total = TB'($urandom_range(0, 5000));
                    default: current_total = TB'($urandom_range(0, 99));
                endcase
            end
            i_trigger_return = ($urandom_range(0, 11) == 0);
            i_activity       = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
